// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding and default MISR/LFSR constants.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Also used by the pattern controller's LFSR, so both ends agree by default.
  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold the MSB through POLY, XOR in the word.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] fb;

  assign fb = sig[WIDTH-1] ? POLY : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
    end
  end

endmodule

// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compacts NUM_RESP words into a MISR, then compares against GOLDEN.
module bist_resp_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] GOLDEN   = '0,
  parameter int               NUM_RESP = 16,
  parameter int               TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             timeout_err,
  output logic [WIDTH-1:0] signature
);

  localparam int              IW        = $clog2(TIMEOUT);
  localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [15:0]     RESP_LAST = 16'(NUM_RESP - 1);

  state_t          state, state_nxt;
  logic [15:0]     resp_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            load;
  logic            accept;
  logic            timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    resp_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        resp_ready = 1'b1;
        accept     = resp_valid;
        // A final word arriving on the last allowed cycle beats the timeout.
        timeout_hit = !resp_valid && (idle_cnt == IDLE_LAST);
        if (accept && (resp_cnt == RESP_LAST)) begin
          state_nxt = CHECK;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_cnt    <= '0;
      idle_cnt    <= '0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
    end else if (load) begin
      resp_cnt    <= '0;
      idle_cnt    <= '0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
    end else if (state == RUN) begin
      if (accept) begin
        resp_cnt <= resp_cnt + 16'd1;
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LAST) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (timeout_hit) begin
        fail        <= 1'b1;
        timeout_err <= 1'b1;
      end
    end else if (state == CHECK) begin
      fail <= (signature != GOLDEN);
    end
  end

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (accept),
    .din  (resp_data),
    .sig  (signature)
  );

endmodule

// File: doc/bist_resp_analyzer.md
Name: bist_resp_analyzer

Overview:
- Response-side end of the BIST loop. The pattern-generating controller drives stimuli into the circuit under test; this block consumes the resulting response words.
- Compacts the responses into a multiple-input signature register (MISR), counts them, and compares the final signature against a golden value.
- Reports done/fail back to the BIST top using the same start/done/fail handshake style as the controller.

Parameters:
- WIDTH, 8: response word and signature width (4..32).
- POLY, 8'h1D: MISR feedback polynomial taps; bit i set means the tap is XORed into bit i.
- SEED, 8'h00: signature value loaded on start.
- GOLDEN, 8'h00: expected final signature.
- NUM_RESP, 16: number of response words per run (1..65535).
- TIMEOUT, 64: maximum idle cycles between accepted words before the run aborts (>=2).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: level or pulse; sampled in IDLE and DONE only.
- resp_valid, input, 1: response word present.
- resp_data, input, WIDTH: response word.
- resp_ready, output, 1: analyzer accepts a word this cycle.
- busy, output, 1: run in progress.
- done, output, 1: run finished; held until the next start.
- fail, output, 1: valid only while done=1; 1 means signature mismatch or timeout.
- timeout_err, output, 1: valid only while done=1; 1 means the run was aborted by timeout.
- signature, output, WIDTH: current MISR contents.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, signature=SEED, counters=0, all 1-bit outputs=0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE -> RUN on start=1.
  - Same edge: signature<=SEED, resp_cnt<=0, idle_cnt<=0, done<=0, fail<=0, timeout_err<=0.
- DONE -> RUN on start=1, with the same loads. start is ignored in RUN and CHECK.
- RUN:
  - busy=1; resp_ready=1 combinationally.
  - A word is accepted on any edge where resp_valid=1.
  - On accept: signature <= ({sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0)) ^ resp_data; resp_cnt+1; idle_cnt<=0.
  - No accept: idle_cnt+1.
  - Accept of word NUM_RESP (resp_cnt==NUM_RESP-1) -> CHECK. resp_ready drops the next cycle; extra words are not accepted.
  - idle_cnt reaching TIMEOUT-1 with no accept that cycle -> DONE with fail=1, timeout_err=1. Signature is frozen.
  - If the final word and the timeout coincide, the accept wins.
- CHECK: one cycle, busy=1, resp_ready=0. fail <= (signature != GOLDEN); -> DONE.
- DONE: busy=0, done=1, signature held.
- Latency:
  - done rises 2 cycles after the edge that accepts the final word: one edge into CHECK, one edge into DONE.
  - done rises exactly TIMEOUT cycles after the last accept, or after the RUN entry if no word was accepted.
- Counter widths:
  - resp_cnt is 16 bits.
  - idle_cnt is clog2(TIMEOUT) bits and saturates; it never wraps.
- Reset mid-run aborts immediately to IDLE and leaves no residual done/fail.
- resp_data is ignored whenever resp_ready=0.

Decomposition:
- Shared package bist_pkg holds:
  - the FSM state enum (IDLE, RUN, CHECK, DONE), 2-bit encoding;
  - default POLY/SEED constants, shared with the controller's LFSR.
- One natural sub-module, bist_misr: WIDTH/POLY/SEED parameters; ports clk, rst, load, en, din, sig.
- The FSM, counters and compare stay in bist_resp_analyzer.

Test Plan:
- Pass case:
  - Setup: WIDTH=8, POLY=8'h1D, SEED=0, NUM_RESP=2, GOLDEN=8'h00.
  - Stimulus: start, then 8'h01, 8'h02 on consecutive cycles.
  - Required: signature 01 then 00; done=1 two cycles after the second accept; fail=0.
- Polynomial feedback:
  - Setup: NUM_RESP=2, GOLDEN=8'h1D.
  - Stimulus: 8'h80, 8'h00.
  - Required: signature 80 then 1D; fail=0.
  - Rerun with GOLDEN=8'h1C: fail=1, timeout_err=0.
- Gaps and extra words:
  - Stimulus: resp_valid low for 10 cycles between words (TIMEOUT=64), then a third word presented after NUM_RESP=2 words.
  - Required: same signature as the gapless run; resp_ready=0 during CHECK/DONE; the third word is not absorbed.
- Timeout:
  - Stimulus: start, one word, then resp_valid=0 (TIMEOUT=64).
  - Required: done=1, fail=1, timeout_err=1 exactly 64 cycles after the accept.
  - Final word on the last allowed cycle: no timeout.
- Async reset mid-run:
  - Stimulus: rst=0 for 3ns between edges during RUN.
  - Required: outputs clear immediately, signature=SEED, state IDLE.
  - A new start then runs normally.
- Restart from DONE:
  - Stimulus: start while done=1.
  - Required: done/fail/timeout_err clear on the next edge; signature reloads to SEED; busy=1.
